// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives open-collector ps2_clk/ps2_data through output enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 975000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT
    } state_t;

    logic          clk_meta_q, clk_sync_q;
    logic          data_meta_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;

    state_t        state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] to_q, to_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tout_q, tout_d;
    logic          to_run, to_hit;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    // Clock filter: the level flips only after FILTER_LEN differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall_d = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (fcnt_q == F_LAST) begin
                filt_d = clk_sync_q;
                fall_d = ~clk_sync_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Filter state and registered falling-edge tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
        end
    end

    assign to_run = (state_q == S_SEND) || (state_q == S_ACK) ||
                    (state_q == S_WAIT);
    assign to_hit = to_run && (to_q == TO_LAST);

    // Transfer sequencing; a timeout overrides any completing event.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_d     = inh_q;
        to_d      = to_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tout_d    = 1'b0;

        if (to_run && (to_q != TO_LAST)) begin
            to_d = to_q + TW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                inh_d     = '0;
                to_d      = '0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    state_d = S_REQ;
                end else begin
                    inh_d = inh_q + IW'(1);
                end
            end
            S_REQ: begin
                data_oe_d = 1'b1;
                to_d      = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (bit_cnt_q == 4'd10) begin
                    state_d = S_ACK;
                end else if (fall_q) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                data_oe_d = 1'b0;
                if (fall_q) begin
                    if (!data_sync_q) begin
                        state_d = S_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (clk_sync_q && data_sync_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (to_hit) begin
            state_d   = S_IDLE;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            tout_d    = 1'b1;
        end
    end

    // Main state, datapath and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_q     <= '0;
            to_q      <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tout_q    <= tout_d;
        end
    end

    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign ps2_data_oe = (state_q == S_REQ) ||
                         ((state_q == S_SEND) && data_oe_q);
    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ack_err     = err_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a PS/2 device model.
// Expected frames come from the byte, odd parity and stop rules.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 3000;
    localparam int FL  = 8;
    localparam int H   = 30;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    logic dev_clk_low;
    logic dev_data_low;

    int vec_n, err_n;
    int done_n, aerr_n, tout_n;
    int exp_done, exp_aerr, exp_tout;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(FL)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .ack_err(ack_err),
        .timeout(timeout)
    );

    // Open-collector bus: either side pulling low wins.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse-cycle totals; a stretched pulse inflates these.
    always @(negedge clk) begin
        done_n += int'(done);
        aerr_n += int'(ack_err);
        tout_n += int'(timeout);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [7:0] d, input bit keep);
        @(negedge clk);
        chk("ready_idle", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("busy_after_accept", {busy, tx_ready}, 2'b10);
        if (!keep) tx_valid = 1'b0;
    endtask

    // mode 0: ack, 1: no ack, 2: reset after fall 4, 3: device silent
    task automatic run_xfer(input logic [7:0] d, input logic [7:0] nd,
                            input int mode, input bit glitch,
                            input bit keep);
        int n;
        logic [9:0] exp_bits;
        logic [9:0] got;
        logic acc;
        for (int i = 0; i < 8; i++)
            exp_bits[i] = ((int'(d) >> i) % 2) == 1;
        exp_bits[8] = ($countones(d) % 2) == 0;
        exp_bits[9] = 1'b1;
        got = '0;

        n = 0;
        while (!ps2_clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("inhibit_start", ps2_clk_oe, 1);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 100) begin
            @(negedge clk);
            n++;
        end
        chk("inhibit_len", n, INH);
        tx_data  = nd;
        tx_valid = keep;
        chk("req_both_low", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        @(negedge clk);
        chk("release_start", {ps2_clk_oe, ps2_data_oe}, 2'b01);

        if (mode == 3) begin
            n = 0;
            while (!timeout && n < TO + 50) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_at", n, TO);
            chk("timeout_pulse", {timeout, done, ack_err}, 3'b100);
            chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            chk("timeout_ready", tx_ready, 1);
            exp_tout++;
            return;
        end

        repeat (H) @(negedge clk);
        for (int f = 1; f <= 10; f++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            got[f-1] = ps2_data_in;
            if (mode == 2 && f == 4) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_async_oe", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
                dev_clk_low = 1'b0;
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
                acc = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    acc = acc | done | ack_err | timeout | busy;
                end
                chk("rst_no_pulse", acc, 0);
                chk("rst_ready", tx_ready, 1);
                return;
            end
            dev_clk_low = 1'b0;
            if (f == 5 && glitch) begin
                repeat (15) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H - 18) @(negedge clk);
            end else begin
                if (f == 10 && mode == 0) dev_data_low = 1'b1;
                repeat (H) @(negedge clk);
            end
        end
        chk("frame_bits", got, exp_bits);

        dev_clk_low = 1'b1;
        if (mode == 1) begin
            n = 0;
            while (!(done | ack_err | timeout) && n < H) begin
                @(negedge clk);
                n++;
            end
            chk("ack_err_pulse", {ack_err, done, timeout}, 3'b100);
            chk("ack_err_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            chk("ack_err_idle", {tx_ready, busy}, 2'b10);
            exp_aerr++;
            repeat (H - n) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
            chk("wait_busy", busy, 1);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            n = 0;
            while (!(done | ack_err | timeout) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("done_pulse", {done, ack_err, timeout}, 3'b100);
            chk("done_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            chk("done_ready", tx_ready, 1);
            exp_done++;
        end
    endtask

    initial begin
        logic [7:0] d, d2;
        int m;
        bit g;
        logic acc;
        vec_n = 0; err_n = 0;
        done_n = 0; aerr_n = 0; tout_n = 0;
        exp_done = 0; exp_aerr = 0; exp_tout = 0;
        rst_n = 1'b0;
        tx_data = '0;
        tx_valid = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;

        repeat (4) @(negedge clk);
        chk("reset_outs",
            {ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", tx_ready, 1);

        start_req(8'hF4, 0);
        run_xfer(8'hF4, 8'($urandom), 0, 0, 0);
        start_req(8'h00, 0);
        run_xfer(8'h00, 8'($urandom), 0, 0, 0);
        start_req(8'hF3, 0);
        run_xfer(8'hF3, 8'($urandom), 0, 0, 0);
        d = 8'($urandom);
        start_req(d, 0);
        run_xfer(d, 8'($urandom), 0, 0, 0);

        start_req(8'hA5, 0);
        run_xfer(8'hA5, 8'($urandom), 1, 0, 0);

        start_req(8'hFF, 0);
        run_xfer(8'hFF, 8'($urandom), 3, 0, 0);

        start_req(8'h00, 0);
        run_xfer(8'h00, 8'($urandom), 2, 0, 0);

        d = 8'($urandom);
        start_req(d, 0);
        run_xfer(d, 8'($urandom), 0, 1, 0);

        d  = 8'($urandom);
        d2 = 8'($urandom);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        run_xfer(d, d2, 0, 0, 1);
        run_xfer(d2, 8'($urandom), 0, 0, 0);
        acc = 1'b0;
        repeat (100) begin
            @(negedge clk);
            acc = acc | ps2_clk_oe | busy;
        end
        chk("b2b_no_extra", acc, 0);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 1 : 0;
            g = 1'($urandom_range(0, 1));
            start_req(d, 0);
            run_xfer(d, 8'($urandom), m, g, 0);
        end

        repeat (5) @(negedge clk);
        chk("total_done", done_n, exp_done);
        chk("total_ack_err", aerr_n, exp_aerr);
        chk("total_timeout", tout_n, exp_tout);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
